// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for an RV32I integer subset: sequences fetch/decode/exec/mem/wb and drives datapath controls.
// Optional feature macro: CTRL_BNE_EN enables BNE decode (otherwise BNE traps as illegal).
module cpu_ctrl_fsm #(
  parameter int D_WIDTH = 32,
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               fetch_req,
  output logic               ir_we,
  output logic               mem_req,
  output logic               mem_we,
  output logic [OP_SIZE-1:0] alu_op,
  output logic               alu_src_imm,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic               pc_we,
  output logic               pc_src,
  output logic               illegal,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6,
    TRAP   = 3'd7
  } state_t;

  localparam int SHAMT_W = $clog2(D_WIDTH);

  localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_SLT = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_SLL = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] OP_SRL = OP_SIZE'(7);

  state_t      state_reg, state_next;
  logic [31:0] ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ir_q      <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_we) ir_q <= instr;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_bne;
  logic       is_alu, is_ls, is_br;
  logic       shift_hi_zero;
  logic       unused_ir_bits;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);
`ifdef CTRL_BNE_EN
  assign is_bne = (opcode == 7'b1100011) && (funct3 == 3'b001);
`else
  assign is_bne = 1'b0;
`endif
  assign is_alu = is_r | is_i;
  assign is_ls  = is_lw | is_sw;
  assign is_br  = is_beq | is_bne;

  // Shifts need every bit above the shift amount clear; this rejects SRA/SRAI and malformed shifts.
  assign shift_hi_zero  = (ir_q[31:20+SHAMT_W] == '0);
  assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

  logic [OP_SIZE-1:0] dec_op;
  logic               dec_ok;

  always_comb begin
    dec_op = OP_ADD;
    dec_ok = 1'b0;
    case (funct3)
      3'b000: begin dec_op = (is_r && ir_q[30]) ? OP_SUB : OP_ADD; dec_ok = 1'b1; end
      3'b111: begin dec_op = OP_AND; dec_ok = 1'b1; end
      3'b110: begin dec_op = OP_OR;  dec_ok = 1'b1; end
      3'b100: begin dec_op = OP_XOR; dec_ok = 1'b1; end
      3'b010: begin dec_op = OP_SLT; dec_ok = 1'b1; end
      3'b001: begin dec_op = OP_SLL; dec_ok = shift_hi_zero; end
      3'b101: begin dec_op = OP_SRL; dec_ok = shift_hi_zero; end
      default: begin dec_op = OP_ADD; dec_ok = 1'b0; end
    endcase
  end

  // Operand setup shared by EXEC and WB so the ALU result stays valid through write-back.
  logic [OP_SIZE-1:0] exec_op;
  logic               exec_imm;
  assign exec_op  = is_ls ? OP_ADD : dec_op;
  assign exec_imm = is_i | is_ls;

  always_comb begin
    state_next  = state_reg;
    fetch_req   = 1'b0;
    ir_we       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    alu_op      = OP_ADD;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    rf_wsel     = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    illegal     = 1'b0;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if ((is_alu && dec_ok) || is_ls) state_next = EXEC;
        else if (is_br)                  state_next = BRANCH;
        else                             state_next = TRAP;
      end
      EXEC: begin
        alu_op      = exec_op;
        alu_src_imm = exec_imm;
        state_next  = is_ls ? MEM : WB;
      end
      MEM: begin
        alu_op      = OP_ADD;
        alu_src_imm = 1'b1;
        mem_req     = 1'b1;
        mem_we      = is_sw;
        if (mem_ready) begin
          pc_we      = is_sw;
          state_next = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        alu_op      = exec_op;
        alu_src_imm = exec_imm;
        rf_we       = 1'b1;
        rf_wsel     = is_lw;
        pc_we       = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        alu_op     = OP_SUB;
        pc_we      = 1'b1;
        pc_src     = is_bne ? ~alu_zero : alu_zero;
        state_next = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign state = state_reg;

endmodule
